// File: rtl/treasure_color_classifier.sv
`default_nettype none
// ============================================================================
// Module      : treasure_color_classifier
// Description : Counts red- and blue-dominant RGB332 pixels in the active
//               window of each scanned frame, issues a per-frame verdict and
//               debounces it over several frames before driving RESULT.
// Revision    : 1.0 - initial release
// ============================================================================
module treasure_color_classifier #(
    parameter int          IMG_W     = 176,
    parameter int          IMG_H     = 144,
    parameter logic [2:0]  RED_THR   = 3'd5,
    parameter logic [1:0]  BLUE_THR  = 2'd2,
    parameter logic [2:0]  G_MAX     = 3'd3,
    parameter logic [14:0] COUNT_THR = 15'd2000,
    parameter int          STABLE_N  = 3
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [7:0]  PIXEL_IN,
    input  logic [9:0]  VGA_PIXEL_X,
    input  logic [9:0]  VGA_PIXEL_Y,
    output logic [2:0]  RESULT,
    output logic        FRAME_DONE,
    output logic [14:0] RED_COUNT,
    output logic [14:0] BLUE_COUNT
);

    localparam logic [9:0]  W_LIM   = 10'(IMG_W);
    localparam logic [9:0]  H_LIM   = 10'(IMG_H);
    localparam logic [9:0]  H_LAST  = 10'(IMG_H - 1);
    localparam logic [14:0] ACC_MAX = 15'h7FFF;

    localparam int              SW         = $clog2(STABLE_N + 1);
    localparam logic [SW-1:0]   STABLE_MAX = SW'(STABLE_N);
    localparam logic [SW-1:0]   STABLE_ONE = SW'(1);

    localparam logic [1:0] COL_NONE = 2'b00;
    localparam logic [1:0] COL_RED  = 2'b01;
    localparam logic [1:0] COL_BLUE = 2'b10;

    localparam logic [1:0] ST_WAIT_SOF = 2'd0;
    localparam logic [1:0] ST_ACCUM    = 2'd1;
    localparam logic [1:0] ST_DECIDE   = 2'd2;
    localparam logic [1:0] ST_UPDATE   = 2'd3;

    logic [1:0]    state;
    logic [9:0]    x_d;
    logic [9:0]    y_d;
    logic [9:0]    y_dd;
    logic [14:0]   red_acc;
    logic [14:0]   blue_acc;
    logic [1:0]    verdict_q;
    logic [1:0]    candidate;
    logic [SW-1:0] stable_cnt;

    logic [2:0]    pix_r;
    logic [2:0]    pix_g;
    logic [1:0]    pix_b;
    logic          is_red;
    logic          is_blue;
    logic          active;
    logic          sof;
    logic          bottom;
    logic          red_hit;
    logic          blue_hit;
    logic [1:0]    frame_verdict;
    logic [SW-1:0] next_stable;

    assign pix_r = PIXEL_IN[7:5];
    assign pix_g = PIXEL_IN[4:2];
    assign pix_b = PIXEL_IN[1:0];

    // The two colour tests are disjoint: red needs B<=1, blue needs B>=2.
    assign is_red  = (pix_r >= RED_THR) && (pix_g <= G_MAX) && (pix_b <= 2'd1);
    assign is_blue = (pix_b >= BLUE_THR) && (pix_g <= G_MAX) && (pix_r <= 3'd2);

    // Delayed coordinates line up with the pixel the memory returns now.
    assign active   = (x_d < W_LIM) && (y_d < H_LIM);
    assign sof      = (x_d == 10'd0) && (y_d == 10'd0);
    assign bottom   = (y_d == H_LIM) && (y_dd == H_LAST);
    assign red_hit  = active && is_red;
    assign blue_hit = active && is_blue;

    assign FRAME_DONE = (state == ST_DECIDE);

    // Frame verdict from the finished accumulators; ties fall to NONE.
    always_comb begin
        frame_verdict = COL_NONE;
        if ((red_acc > blue_acc) && (red_acc >= COUNT_THR)) begin
            frame_verdict = COL_RED;
        end else if ((blue_acc > red_acc) && (blue_acc >= COUNT_THR)) begin
            frame_verdict = COL_BLUE;
        end
    end

    // Debounce counter step: saturate on agreement, restart on change.
    always_comb begin
        next_stable = STABLE_ONE;
        if (verdict_q == candidate) begin
            next_stable = (stable_cnt >= STABLE_MAX) ? STABLE_MAX : stable_cnt + STABLE_ONE;
        end
    end

    // Coordinate pipeline; reset to all-ones so reset never looks like (0,0).
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            x_d  <= '1;
            y_d  <= '1;
            y_dd <= '1;
        end else begin
            x_d  <= VGA_PIXEL_X;
            y_d  <= VGA_PIXEL_Y;
            y_dd <= y_d;
        end
    end

    // Frame sequencing: start of frame, bottom edge, decide, update.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state <= ST_WAIT_SOF;
        end else begin
            case (state)
                ST_WAIT_SOF: if (sof) state <= ST_ACCUM;
                ST_ACCUM:    if (!sof && bottom) state <= ST_DECIDE;
                ST_DECIDE:   state <= ST_UPDATE;
                default:     state <= ST_WAIT_SOF;
            endcase
        end
    end

    // Saturating pixel counters; a (0,0) restarts them with the (0,0) pixel itself.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            red_acc  <= '0;
            blue_acc <= '0;
        end else if ((state == ST_WAIT_SOF || state == ST_ACCUM) && sof) begin
            red_acc  <= {14'd0, red_hit};
            blue_acc <= {14'd0, blue_hit};
        end else if (state == ST_ACCUM) begin
            if (red_hit && (red_acc != ACC_MAX)) red_acc <= red_acc + 15'd1;
            if (blue_hit && (blue_acc != ACC_MAX)) blue_acc <= blue_acc + 15'd1;
        end
    end

    // Latch per-frame results in DECIDE, then debounce into RESULT in UPDATE.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            RED_COUNT  <= '0;
            BLUE_COUNT <= '0;
            verdict_q  <= COL_NONE;
            candidate  <= COL_NONE;
            stable_cnt <= '0;
            RESULT     <= 3'b000;
        end else if (state == ST_DECIDE) begin
            RED_COUNT  <= red_acc;
            BLUE_COUNT <= blue_acc;
            verdict_q  <= frame_verdict;
        end else if (state == ST_UPDATE) begin
            candidate  <= verdict_q;
            stable_cnt <= next_stable;
            if (next_stable == STABLE_MAX) begin
                RESULT <= {1'b1, verdict_q};
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_treasure_color_classifier.sv
`default_nettype none
// ============================================================================
// Module      : tb_treasure_color_classifier
// Description : Directed bench for treasure_color_classifier. A reduced
//               16x12 instance exercises the decision logic over many frames;
//               a default-size instance checks one full 176x144 frame.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_treasure_color_classifier;

    localparam int          SW_W   = 16;
    localparam int          SW_H   = 12;
    localparam logic [14:0] SM_THR = 15'd40;
    localparam int          FW     = 176;
    localparam int          FH     = 144;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  pix;
    logic [9:0]  px;
    logic [9:0]  py;
    logic [2:0]  result;
    logic        frame_done;
    logic [14:0] red_count;
    logic [14:0] blue_count;
    logic [2:0]  f_result;
    logic        f_frame_done;
    logic [14:0] f_red;
    logic [14:0] f_blue;
    logic [7:0]  pend = 8'h00;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    treasure_color_classifier #(
        .IMG_W     (SW_W),
        .IMG_H     (SW_H),
        .COUNT_THR (SM_THR)
    ) dut (
        .CLK         (clk),
        .RESET       (rst),
        .PIXEL_IN    (pix),
        .VGA_PIXEL_X (px),
        .VGA_PIXEL_Y (py),
        .RESULT      (result),
        .FRAME_DONE  (frame_done),
        .RED_COUNT   (red_count),
        .BLUE_COUNT  (blue_count)
    );

    treasure_color_classifier dut_full (
        .CLK         (clk),
        .RESET       (rst),
        .PIXEL_IN    (pix),
        .VGA_PIXEL_X (px),
        .VGA_PIXEL_Y (py),
        .RESULT      (f_result),
        .FRAME_DONE  (f_frame_done),
        .RED_COUNT   (f_red),
        .BLUE_COUNT  (f_blue)
    );

    // Pixel content: 0 all red, 1 all blue, 3 first n active pixels red,
    // 4 sixty red + sixty blue active pixels with red in every blanking slot.
    function automatic logic [7:0] pix_val(int mode, int n, int x, int y, int w, int h);
        int idx;
        idx = y * w + x;
        case (mode)
            0: return 8'hE0;
            1: return 8'h03;
            3: return (x < w && y < h && idx < n) ? 8'hE0 : 8'h00;
            4: begin
                if (x >= w || y >= h) return 8'hE0;
                if (idx < 60) return 8'hE0;
                if (idx < 120) return 8'h03;
                return 8'h00;
            end
            default: return 8'h00;
        endcase
    endfunction

    // Raster scan x=0..w, rows y_first..y_last; memory data trails by one cycle.
    task automatic scan(input int mode, input int n, input int w, input int h,
                        input int y_first, input int y_last,
                        output int pulses, output int f_pulses);
        pulses = 0;
        f_pulses = 0;
        for (int y = y_first; y <= y_last; y++) begin
            for (int x = 0; x <= w; x++) begin
                @(negedge clk);
                if (frame_done) pulses++;
                if (f_frame_done) f_pulses++;
                pix  = pend;
                px   = 10'(x);
                py   = 10'(y);
                pend = pix_val(mode, n, x, y, w, h);
            end
        end
    endtask

    task automatic small_frame(input int mode, input int n, output int pulses);
        int fp;
        scan(mode, n, SW_W, SW_H, 0, SW_H, pulses, fp);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        pix = 8'h00;
        px  = 10'd600;
        py  = 10'd600;
        repeat (3) @(negedge clk);
        n_cmp++; if (result !== 3'b000) begin n_bad++; $display("FAIL reset_result: got %b want 000", result); end
        n_cmp++; if (frame_done !== 1'b0) begin n_bad++; $display("FAIL reset_frame_done: got %b want 0", frame_done); end
        n_cmp++; if (red_count !== 15'd0) begin n_bad++; $display("FAIL reset_red_count: got %0d want 0", red_count); end
        n_cmp++; if (blue_count !== 15'd0) begin n_bad++; $display("FAIL reset_blue_count: got %0d want 0", blue_count); end
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_red_frames();
        int p;
        small_frame(0, 0, p);
        n_cmp++; if (p !== 1) begin n_bad++; $display("FAIL red1_pulses: got %0d want 1", p); end
        n_cmp++; if (red_count !== 15'd192) begin n_bad++; $display("FAIL red1_red_count: got %0d want 192", red_count); end
        n_cmp++; if (blue_count !== 15'd0) begin n_bad++; $display("FAIL red1_blue_count: got %0d want 0", blue_count); end
        n_cmp++; if (result !== 3'b000) begin n_bad++; $display("FAIL red1_result: got %b want 000", result); end
        small_frame(0, 0, p);
        n_cmp++; if (result !== 3'b000) begin n_bad++; $display("FAIL red2_result: got %b want 000", result); end
        small_frame(0, 0, p);
        n_cmp++; if (p !== 1) begin n_bad++; $display("FAIL red3_pulses: got %0d want 1", p); end
        n_cmp++; if (result !== 3'b101) begin n_bad++; $display("FAIL red3_result: got %b want 101", result); end
    endtask

    task automatic test_reset_mid_accum();
        int p;
        int fp;
        scan(0, 0, SW_W, SW_H, 0, 4, p, fp);
        #2 rst = 1'b1;
        #1;
        n_cmp++; if (result !== 3'b000) begin n_bad++; $display("FAIL async_result: got %b want 000", result); end
        n_cmp++; if (frame_done !== 1'b0) begin n_bad++; $display("FAIL async_frame_done: got %b want 0", frame_done); end
        n_cmp++; if (red_count !== 15'd0) begin n_bad++; $display("FAIL async_red_count: got %0d want 0", red_count); end
        n_cmp++; if (blue_count !== 15'd0) begin n_bad++; $display("FAIL async_blue_count: got %0d want 0", blue_count); end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        scan(0, 0, SW_W, SW_H, 5, SW_H, p, fp);
        n_cmp++; if (p !== 0) begin n_bad++; $display("FAIL post_reset_partial_pulses: got %0d want 0", p); end
        small_frame(0, 0, p);
        n_cmp++; if (p !== 1) begin n_bad++; $display("FAIL post_reset_full_pulses: got %0d want 1", p); end
        n_cmp++; if (red_count !== 15'd192) begin n_bad++; $display("FAIL post_reset_red_count: got %0d want 192", red_count); end
        n_cmp++; if (result !== 3'b000) begin n_bad++; $display("FAIL post_reset_result: got %b want 000", result); end
    endtask

    task automatic test_blue_then_red();
        int p;
        repeat (3) small_frame(1, 0, p);
        n_cmp++; if (blue_count !== 15'd192) begin n_bad++; $display("FAIL blue3_blue_count: got %0d want 192", blue_count); end
        n_cmp++; if (result !== 3'b110) begin n_bad++; $display("FAIL blue3_result: got %b want 110", result); end
        small_frame(0, 0, p);
        n_cmp++; if (result !== 3'b110) begin n_bad++; $display("FAIL blue_hold_result: got %b want 110", result); end
        n_cmp++; if (dut.stable_cnt !== 2'd1) begin n_bad++; $display("FAIL blue_hold_stable: got %0d want 1", dut.stable_cnt); end
    endtask

    task automatic test_threshold();
        int p;
        small_frame(3, 39, p);
        n_cmp++; if (red_count !== 15'd39) begin n_bad++; $display("FAIL thr1_red_count: got %0d want 39", red_count); end
        n_cmp++; if (result !== 3'b110) begin n_bad++; $display("FAIL thr1_result: got %b want 110", result); end
        small_frame(3, 39, p);
        small_frame(3, 39, p);
        n_cmp++; if (result !== 3'b100) begin n_bad++; $display("FAIL thr3_result: got %b want 100", result); end
        small_frame(3, 40, p);
        n_cmp++; if (red_count !== 15'd40) begin n_bad++; $display("FAIL thr_at_red_count: got %0d want 40", red_count); end
        n_cmp++; if (dut.candidate !== 2'b01) begin n_bad++; $display("FAIL thr_at_candidate: got %b want 01", dut.candidate); end
        n_cmp++; if (result !== 3'b100) begin n_bad++; $display("FAIL thr_at_result: got %b want 100", result); end
    endtask

    task automatic test_tie_and_blanking();
        int p;
        small_frame(4, 0, p);
        n_cmp++; if (red_count !== 15'd60) begin n_bad++; $display("FAIL tie_red_count: got %0d want 60", red_count); end
        n_cmp++; if (blue_count !== 15'd60) begin n_bad++; $display("FAIL tie_blue_count: got %0d want 60", blue_count); end
        n_cmp++; if (dut.candidate !== 2'b00) begin n_bad++; $display("FAIL tie_candidate: got %b want 00", dut.candidate); end
        n_cmp++; if (dut.stable_cnt !== 2'd1) begin n_bad++; $display("FAIL tie_stable: got %0d want 1", dut.stable_cnt); end
    endtask

    task automatic test_restart();
        int p;
        int fp;
        scan(0, 0, SW_W, SW_H, 0, 5, p, fp);
        n_cmp++; if (p !== 0) begin n_bad++; $display("FAIL restart_partial_pulses: got %0d want 0", p); end
        n_cmp++; if (red_count !== 15'd60) begin n_bad++; $display("FAIL restart_red_hold: got %0d want 60", red_count); end
        small_frame(1, 0, p);
        n_cmp++; if (p !== 1) begin n_bad++; $display("FAIL restart_full_pulses: got %0d want 1", p); end
        n_cmp++; if (red_count !== 15'd0) begin n_bad++; $display("FAIL restart_red_count: got %0d want 0", red_count); end
        n_cmp++; if (blue_count !== 15'd192) begin n_bad++; $display("FAIL restart_blue_count: got %0d want 192", blue_count); end
    endtask

    task automatic test_full_size_frame();
        int p;
        int fp;
        scan(0, 0, FW, FH, 0, FH, p, fp);
        n_cmp++; if (fp !== 1) begin n_bad++; $display("FAIL full_pulses: got %0d want 1", fp); end
        n_cmp++; if (f_red !== 15'd25344) begin n_bad++; $display("FAIL full_red_count: got %0d want 25344", f_red); end
        n_cmp++; if (f_blue !== 15'd0) begin n_bad++; $display("FAIL full_blue_count: got %0d want 0", f_blue); end
        n_cmp++; if (f_result !== 3'b000) begin n_bad++; $display("FAIL full_result: got %b want 000", f_result); end
    endtask

    initial begin
        test_reset();
        test_red_frames();
        test_reset_mid_accum();
        test_blue_then_red();
        test_threshold();
        test_tie_and_blanking();
        test_restart();
        test_full_size_frame();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
